booth_mac_accum: RTL and testbench

- Downstream consumer of the 4-bit radix-2 Booth multiplier.
- Detects each multiply completion (busy falling edge) and samples the signed 8-bit product.
- Accumulates GROUP_N consecutive products into a signed running sum, then presents the sum through a one-entry valid/ready output register.
- Forms the accumulate half of a small dot-product/MAC datapath.

---
 rtl/booth_pkg.sv | 54 +++++
 rtl/booth_done_detect.sv | 20 ++
 rtl/booth_mac_accum.sv | 147 ++++++++++++++
 tb/tb_booth_mac_accum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and arithmetic helpers for the Booth MAC datapath.
// Optional feature macro: BOOTH_MAC_SAT_EN (saturating accumulate adds).
package booth_pkg;

    // Product width is fixed by the upstream 4-bit radix-2 Booth multiplier.
    localparam int PROD_W    = 8;
    localparam int ACC_W_DEF = 12;
    // Helpers work on a fixed wide container; callers keep the low ACC_W bits.
    localparam int MAX_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } add_res_t;

    // Sign-extend a product into the wide container.
    function automatic logic [MAX_W-1:0] sext_prod(input logic [PROD_W-1:0] prod);
        return MAX_W'($signed(prod));
    endfunction

    // Signed add of two w-bit values (held sign-extended in MAX_W bits).
    // Overflow is detected as "exact sum not representable in w bits",
    // which is the same condition as equal operand signs with a flipped
    // result sign. The result either wraps or saturates to the w-bit range.
    function automatic add_res_t add_ovf(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input int unsigned      w);
        longint   s;
        longint   hi;
        longint   lo;
        longint   span;
        add_res_t r;
        span  = longint'(1) << w;
        hi    = (span >>> 1) - 1;
        lo    = -(span >>> 1);
        s     = longint'($signed(a)) + longint'($signed(b));
        r.ovf = (s > hi) || (s < lo);
`ifdef BOOTH_MAC_SAT_EN
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
`else
        if (s > hi)      s = s - span;
        else if (s < lo) s = s + span;
`endif
        r.sum = s[MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/booth_done_detect.sv
// Multiply-completion detector: registers busy and pulses o_cap on the
// cycle where busy has just fallen (the product is valid in that cycle).
module booth_done_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    output logic o_cap
);

    logic r_busy_q;

    // Delay busy by one cycle; reset low so a low busy never looks like a fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy_q <= 1'b0;
        else       r_busy_q <= i_busy;
    end

    assign o_cap = r_busy_q & ~i_busy;

endmodule

// File: rtl/booth_mac_accum.sv
// Booth MAC accumulator: sums GROUP_N consecutive multiplier products and
// presents each group sum through a one-entry valid/ready output register.
// Optional feature macro: BOOTH_MAC_SAT_EN (adds saturate instead of wrap).
// ACC_W range supported: PROD_W .. MAX_W-1. GROUP_N range: 1..255.
module booth_mac_accum
    import booth_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int GROUP_N = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic [PROD_W-1:0] i_prod,
    input  logic              i_busy,
    output logic [ACC_W-1:0]  o_acc_out,
    output logic              o_acc_valid,
    input  logic              i_acc_ready,
    output logic              o_ovf,
    output logic              o_overrun
);

    // Registered state
    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [7:0]        r_cnt;
    logic        [ACC_W-1:0]  r_acc_out;
    logic                     r_acc_valid;
    logic                     r_ovf;
    logic                     r_overrun;

    // Next-state and datapath wires
    state_t                   w_state_n;
    logic signed [ACC_W-1:0]  w_acc_n;
    logic        [7:0]        w_cnt_n;
    logic        [ACC_W-1:0]  w_acc_out_n;
    logic                     w_acc_valid_n;
    logic                     w_ovf_n;
    logic                     w_overrun_n;
    logic                     w_load;
    logic        [ACC_W-1:0]  w_load_val;
    logic                     w_cap;
    logic        [MAX_W-1:0]  w_prod_x;
    logic        [MAX_W-1:0]  w_acc_x;
    add_res_t                 w_add;
    logic                     w_unused;

    booth_done_detect u_done (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_busy (i_busy),
        .o_cap  (w_cap)
    );

    assign w_prod_x = sext_prod(i_prod);
    assign w_acc_x  = MAX_W'(r_acc);
    assign w_add    = add_ovf(w_acc_x, w_prod_x, ACC_W);
    // Upper container bits are only sign copies of the ACC_W-bit value.
    assign w_unused = ^{w_add.sum[MAX_W-1:ACC_W], w_prod_x[MAX_W-1:ACC_W]};

    // Next-state: accumulate on capture, load the group result, run handshake.
    always_comb begin
        w_state_n     = r_state;
        w_acc_n       = r_acc;
        w_cnt_n       = r_cnt;
        w_ovf_n       = r_ovf;
        w_load        = 1'b0;
        w_load_val    = r_acc_out;
        w_acc_out_n   = r_acc_out;
        w_acc_valid_n = r_acc_valid;
        w_overrun_n   = r_overrun;

        if (i_clr) begin
            // Abort wins over a coincident capture; that product is dropped.
            w_state_n = IDLE;
            w_acc_n   = '0;
            w_cnt_n   = '0;
            w_ovf_n   = 1'b0;
        end else if (w_cap) begin
            case (r_state)
                IDLE: begin
                    // First product of a group: plain load, no add, ovf restarts.
                    w_ovf_n = 1'b0;
                    if (GROUP_N == 1) begin
                        w_load     = 1'b1;
                        w_load_val = w_prod_x[ACC_W-1:0];
                    end else begin
                        w_acc_n   = w_prod_x[ACC_W-1:0];
                        w_cnt_n   = 8'd1;
                        w_state_n = ACC;
                    end
                end
                ACC: begin
                    w_ovf_n = r_ovf | w_add.ovf;
                    if (r_cnt == 8'(GROUP_N - 1)) begin
                        w_load     = 1'b1;
                        w_load_val = w_add.sum[ACC_W-1:0];
                        w_acc_n    = '0;
                        w_cnt_n    = '0;
                        w_state_n  = IDLE;
                    end else begin
                        w_acc_n = w_add.sum[ACC_W-1:0];
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end

        // Output register: a load always wins; it only counts as an overrun
        // when the pending result is not being taken on this same edge.
        if (w_load) begin
            w_acc_out_n   = w_load_val;
            w_acc_valid_n = 1'b1;
            if (r_acc_valid && !i_acc_ready) w_overrun_n = 1'b1;
        end else if (r_acc_valid && i_acc_ready) begin
            w_acc_valid_n = 1'b0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_acc_out   <= '0;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_acc       <= w_acc_n;
            r_cnt       <= w_cnt_n;
            r_acc_out   <= w_acc_out_n;
            r_acc_valid <= w_acc_valid_n;
            r_ovf       <= w_ovf_n;
            r_overrun   <= w_overrun_n;
        end
    end

    assign o_acc_out   = r_acc_out;
    assign o_acc_valid = r_acc_valid;
    assign o_ovf       = r_ovf;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: a 12-bit and a 9-bit accumulator share one
// stimulus stream and are compared every cycle against a group-level model.
module tb_booth_mac_accum;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [7:0]  prod;
    logic        busy;
    logic        ready;
    logic [11:0] out12;
    logic        val12;
    logic        ovf12;
    logic        ovr12;
    logic [8:0]  out9;
    logic        val9;
    logic        ovf9;
    logic        ovr9;

    int npass = 0;
    int nchk  = 0;

    booth_mac_accum #(.ACC_W(12), .GROUP_N(4)) dut12 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_prod(prod), .i_busy(busy),
        .o_acc_out(out12), .o_acc_valid(val12), .i_acc_ready(ready),
        .o_ovf(ovf12), .o_overrun(ovr12)
    );

    booth_mac_accum #(.ACC_W(9), .GROUP_N(4)) dut9 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_prod(prod), .i_busy(busy),
        .o_acc_out(out9), .o_acc_valid(val9), .i_acc_ready(ready),
        .o_ovf(ovf9), .o_overrun(ovr9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          cur[$];       // products of the group in progress
    bit          lovf12, lovf9;
    bit          ev, eovr;
    logic [11:0] eo12;
    logic [8:0]  eo9;
    bit          bq;

    // Group sum of w-bit signed adds; o reports any add that overflowed.
    function automatic void fold(input int q[$], input int w, output int s, output bit o);
        longint t;
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        s  = 0;
        o  = 1'b0;
        foreach (q[i]) begin
            t = longint'(s) + longint'(q[i]);
            if (t > hi || t < lo) begin
                o = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
                t = (t > hi) ? hi : lo;
`else
                t = (t > hi) ? t - (hi - lo + 1) : t + (hi - lo + 1);
`endif
            end
            s = int'(t);
        end
    endfunction

    function automatic void model_reset();
        cur.delete();
        lovf12 = 0; lovf9 = 0; ev = 0; eovr = 0; eo12 = '0; eo9 = '0; bq = 0;
    endfunction

    // Apply one rising edge to the model using the currently driven inputs.
    function automatic void model_edge();
        bit cap;
        bit load;
        int s;
        bit o;
        cap  = bq && !busy;
        bq   = busy;
        load = 0;
        if (clr) begin
            cur.delete();
            lovf12 = 0;
            lovf9  = 0;
        end else if (cap) begin
            cur.push_back(int'($signed(prod)));
            if (cur.size() == 4) begin
                load = 1;
                if (ev && !ready) eovr = 1;
                fold(cur, 12, s, o); eo12 = 12'(s); lovf12 = o;
                fold(cur, 9,  s, o); eo9  = 9'(s);  lovf9  = o;
                ev = 1;
                cur.delete();
            end
        end
        if (!load && ev && ready) ev = 0;
    endfunction

    function automatic bit exp_ovf(input int w);
        int s;
        bit o;
        if (cur.size() == 0) return (w == 12) ? lovf12 : lovf9;
        fold(cur, w, s, o);
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("acc_out12",   32'(out12), 32'(eo12));
        chk("acc_valid12", 32'(val12), 32'(ev));
        chk("ovf12",       32'(ovf12), 32'(exp_ovf(12)));
        chk("overrun12",   32'(ovr12), 32'(eovr));
        chk("acc_out9",    32'(out9),  32'(eo9));
        chk("acc_valid9",  32'(val9),  32'(ev));
        chk("ovf9",        32'(ovf9),  32'(exp_ovf(9)));
        chk("overrun9",    32'(ovr9),  32'(eovr));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One multiply: nb busy cycles (garbage on prod), then the capture edge
    // with the real product, ready=rc and clr=cl.
    task automatic mul(input logic [7:0] p, input bit rc, input bit cl, input int nb);
        busy = 1'b1;
        prod = 8'($urandom);
        repeat (nb) tick();
        busy  = 1'b0;
        prod  = p;
        ready = rc;
        clr   = cl;
        tick();
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; clr = 1'b0; prod = '0; busy = 1'b0; ready = 1'b1;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("reset_out12", 32'(out12), 32'h0);
        chk("reset_valid", 32'(val12), 32'h0);
        check_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Four products of +12 -> 48
        for (int i = 0; i < 4; i++) mul(8'h0C, 1, 0, 1);
        chk("grp48_out",   32'(out12), 32'h030);
        chk("grp48_valid", 32'(val12), 32'h1);
        chk("grp48_ovf",   32'(ovf12), 32'h0);
        tick();
        chk("grp48_drain", 32'(val12), 32'h0);

        // Mixed signs, including 0x40 (=-8*-8) -> 62
        mul(8'h0C, 1, 0, 1); mul(8'hFA, 1, 0, 2); mul(8'hF8, 1, 0, 1); mul(8'h40, 1, 0, 3);
        chk("grp62_out", 32'(out12), 32'h03E);
        tick();

        // Backpressure: two groups with ready low -> overrun
        ready = 1'b0;
        mul(8'd1, 0, 0, 1); mul(8'd2, 0, 0, 1); mul(8'd3, 0, 0, 1); mul(8'd4, 0, 0, 1);
        chk("grp10_out", 32'(out12), 32'd10);
        for (int i = 0; i < 4; i++) mul(8'd5, 0, 0, 1);
        chk("grp20_out",     32'(out12), 32'd20);
        chk("grp20_overrun", 32'(ovr12), 32'h1);
        // Third group loads on the same edge as a handshake
        mul(8'd1, 0, 0, 1); mul(8'd1, 0, 0, 1); mul(8'd1, 0, 0, 1); mul(8'd2, 1, 0, 1);
        chk("grp5_out",     32'(out12), 32'd5);
        chk("grp5_valid",   32'(val12), 32'h1);
        chk("grp5_overrun", 32'(ovr12), 32'h1);
        tick();
        chk("grp5_drain", 32'(val12), 32'h0);

        // 9-bit accumulator overflow: four +64
        for (int i = 0; i < 4; i++) mul(8'h40, 1, 0, 1);
`ifdef BOOTH_MAC_SAT_EN
        chk("ovf9_out", 32'(out9), 32'h0FF);
`else
        chk("ovf9_out", 32'(out9), 32'h100);
`endif
        chk("ovf9_flag",  32'(ovf9),  32'h1);
        chk("ovf12_out",  32'(out12), 32'h100);
        chk("ovf12_flag", 32'(ovf12), 32'h0);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf9", 32'(ovf9), 32'h0);

        // clr coincident with a capture drops that product
        mul(8'd3, 1, 0, 1); mul(8'd3, 1, 0, 1); mul(8'd7, 1, 1, 1);
        for (int i = 0; i < 4; i++) mul(8'd1, 1, 0, 1);
        chk("clr_grp_out12", 32'(out12), 32'h004);
        chk("clr_grp_out9",  32'(out9),  32'h004);
        tick();

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            ready = 1'($urandom_range(0, 1));
            mul(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                int'($urandom_range(1, 3)));
            if ($urandom_range(0, 3) == 0) begin
                ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        // Asynchronous reset between edges, with a pending result and partial group
        ready = 1'b0;
        for (int i = 0; i < 4; i++) mul(8'h64, 0, 0, 1);
        mul(8'd9, 0, 0, 1); mul(8'd9, 0, 0, 1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_out12",   32'(out12), 32'h0);
        chk("arst_valid",   32'(val12), 32'h0);
        chk("arst_ovf9",    32'(ovf9),  32'h0);
        chk("arst_overrun", 32'(ovr12), 32'h0);
        check_all();
        #2 rst = 1'b0;
        busy = 1'b0;
        ready = 1'b1;
        repeat (8) tick();
        chk("post_rst_valid", 32'(val12), 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
